mib_slave: RTL
==============

// Module: mib_slave
// PURPOSE
//  Responder end of the MIB bus. Decodes MIB cycles: start, 2 address phases, 2 write-data phases.
//  Matching cycles become single transactions on an internal command bus (intf_cmd master).
//  Acks writes; returns read data as two 16-bit phases. Sits in each MIB-attached FPGA/block
//  on the shared MIB bus; the top level owns the tri-state pads.
// PARAMETERS
//  P_SLAVE_ADDR_HI        8'h00  cycle selected when address phase 1 ad[7:0] == this (byte_addr[23:16])
//  P_CMD_ACK_TIMEOUT_CLKS 16     clocks waited in CMD_WAIT for cmd ack before abandoning the cycle
// PORTS
//  i_sysclk          in   1    clock; all logic and the MIB bus are synchronous to it
//  i_srst_n          in   1    synchronous reset, active low
//  cmd_master        intf      intf_cmd.master: sel, rd_wr_n, byte_addr[23:0], wdata[31:0] out;
//                              rdata[31:0], ack in
//  o_cmd_timeout     out  1    one-clock pulse: internal cmd ack did not arrive in time
//  i_mib_start       in   1    master start strobe, high exactly 1 clk in address phase 1
//  i_mib_rd_wr_n     in   1    1=read 0=write, valid with i_mib_start
//  i_mib_ad          in   16   bus sampled during address and write-data phases
//  o_mib_ad          out  16   read data driven to master
//  o_mib_ad_high_z   out  1    1 = tri-state ad at top level
//  o_mib_slave_ack   out  1    ack to master (bus has pulldown)
//  o_mib_ack_high_z  out  1    1 = tri-state ack at top level
// BEHAVIOUR
//  - Reset (i_srst_n==0 at edge): state IDLE, cmd sel=0, o_cmd_timeout=0, o_mib_slave_ack=0,
//    o_mib_ad_high_z=1, o_mib_ack_high_z=1, counter=0. Reset mid-cycle abandons it; no ack or drive.
//  - i_mib_start, i_mib_rd_wr_n and i_mib_ad are registered once (R regs). All decode uses R copies.
//    R0 = clk after start. R1 = addr[15:0]. R2/R3 = wdata[31:16]/[15:0] (writes only).
//  - All outputs registered; default each clk: sel=0, ack=0, both high_z=1, o_cmd_timeout=0.
//  - FSM:
//    IDLE: R start && R ad[7:0]==P_SLAVE_ADDR_HI -> latch rd flag and addr[23:16] -> ADDR_2.
//      No match, or start seen outside IDLE: ignored, nothing driven.
//    ADDR_2: latch addr[15:0]. Read -> CMD_ISSUE. Write -> WDATA_1.
//    WDATA_1: latch wdata[31:16] -> WDATA_2.
//    WDATA_2: latch wdata[15:0] -> CMD_ISSUE.
//    CMD_ISSUE: sel=1 for exactly 1 clk, with rd_wr_n, byte_addr, wdata -> CMD_WAIT.
//    CMD_WAIT: counter++ each clk.
//      cmd ack: latch rdata, clear counter. Write -> MIB_ACK; read -> RDATA_1.
//      Counter==P_CMD_ACK_TIMEOUT_CLKS-1 without ack: o_cmd_timeout=1 -> IDLE, no MIB ack
//        (master times out). A later stray cmd ack is ignored in IDLE.
//    MIB_ACK: o_mib_slave_ack=1, o_mib_ack_high_z=0 for 1 clk -> IDLE.
//    RDATA_1: ack=1, ack_high_z=0, o_mib_ad=rdata[31:16], ad_high_z=0 -> RDATA_2.
//    RDATA_2: ack=0, ack_high_z=0, o_mib_ad=rdata[15:0], ad_high_z=0 -> IDLE.
//  - Ack is never high >1 clk. ad is driven only in RDATA_1/2, never in any master drive phase.
//  - Master-side budget: cmd ack latency + 6 clk overhead must stay below master MIB timeout (32).
//  - Back-to-back MIB cycles: must accept a new start on the clk after returning to IDLE.
// TESTING
//  - Write 0x00_1234 <= 0xDEADBEEF, P_SLAVE_ADDR_HI=0:
//    one sel pulse, byte_addr=0x001234, wdata=0xDEADBEEF. Cmd ack at +2 -> single 1-clk MIB ack.
//  - Read 0x00_0010, cmd rdata=0xCAFEF00D:
//    ack+ad=0xCAFE one clk, then ad=0xF00D; ad_high_z=0 exactly 2 clks; master mib_master gets 0xCAFEF00D.
//  - Addr hi 0x05 with P_SLAVE_ADDR_HI=0: no sel, ack/ad stay high_z, FSM stays IDLE.
//  - Cmd never acks: o_cmd_timeout pulses 16 clks after CMD_WAIT entry; no MIB ack; next cycle works.
//  - i_srst_n low in WDATA_1 and in RDATA_1: next clk all outputs at reset values; no sel issued.
//  - 10 back-to-back alternating writes/reads via mib_master: all acked, data correct, no master timeouts.

Source files
------------

// File: rtl/mib_slave_if.sv
// Internal command bus between a MIB responder (master side) and the block it serves.
interface intf_cmd;
  logic        sel;
  logic        rd_wr_n;
  logic [23:0] byte_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output sel,
    output rd_wr_n,
    output byte_addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  sel,
    input  rd_wr_n,
    input  byte_addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface

// File: rtl/mib_slave.sv
// MIB bus responder: decodes start / two address phases / two write-data phases, issues one
// internal command per selected cycle, then acks writes or returns read data in two phases.
module mib_slave #(
  parameter logic [7:0]  P_SLAVE_ADDR_HI        = 8'h00,
  parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 16
) (
  input  logic         i_sysclk,
  input  logic         i_srst_n,
  intf_cmd.master      cmd_master,
  output logic         o_cmd_timeout,
  input  logic         i_mib_start,
  input  logic         i_mib_rd_wr_n,
  input  logic [15:0]  i_mib_ad,
  output logic [15:0]  o_mib_ad,
  output logic         o_mib_ad_high_z,
  output logic         o_mib_slave_ack,
  output logic         o_mib_ack_high_z
);

  localparam int unsigned CntW = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);

  typedef enum logic [3:0] {
    StIdle, StAddr2, StWdata1, StWdata2, StCmdIssue, StCmdWait, StMibAck, StRdata1, StRdata2
  } state_e;

  state_e state_q, state_d;

  logic            start_r, rd_wr_n_r;
  logic [15:0]     ad_r;
  logic            rd_q, rd_d;
  logic [23:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_d;
  logic            sel_q, sel_d;
  logic            ack_d, ack_hz_d, ad_hz_d;
  logic [15:0]     ad_d;

  // Next-state and transaction latching; all decode uses the registered bus copies.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_r && (ad_r[7:0] == P_SLAVE_ADDR_HI)) begin
          rd_d           = rd_wr_n_r;
          addr_d[23:16]  = ad_r[7:0];
          state_d        = StAddr2;
        end
      end
      StAddr2: begin
        addr_d[15:0] = ad_r;
        state_d      = rd_q ? StCmdIssue : StWdata1;
      end
      StWdata1: begin
        wdata_d[31:16] = ad_r;
        state_d        = StWdata2;
      end
      StWdata2: begin
        wdata_d[15:0] = ad_r;
        state_d       = StCmdIssue;
      end
      StCmdIssue: begin
        cnt_d   = '0;
        state_d = StCmdWait;
      end
      StCmdWait: begin
        // An ack on the last allowed clock still wins over the timeout.
        if (cmd_master.ack) begin
          rdata_d = cmd_master.rdata;
          cnt_d   = '0;
          state_d = rd_q ? StRdata1 : StMibAck;
        end else if (cnt_q == CntW'(P_CMD_ACK_TIMEOUT_CLKS - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StMibAck: state_d = StIdle;
      StRdata1: state_d = StRdata2;
      StRdata2: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    sel_d    = (state_d == StCmdIssue);
    ack_d    = (state_d == StMibAck) || (state_d == StRdata1);
    ack_hz_d = !((state_d == StMibAck) || (state_d == StRdata1) || (state_d == StRdata2));
    ad_hz_d  = !((state_d == StRdata1) || (state_d == StRdata2));
    ad_d     = 16'h0000;
    if (state_d == StRdata1) ad_d = rdata_d[31:16];
    if (state_d == StRdata2) ad_d = rdata_d[15:0];
  end

  // State, input capture and output registers with synchronous reset.
  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n) begin
      state_q          <= StIdle;
      start_r          <= 1'b0;
      rd_wr_n_r        <= 1'b0;
      ad_r             <= 16'h0000;
      rd_q             <= 1'b0;
      addr_q           <= 24'h000000;
      wdata_q          <= 32'h0000_0000;
      rdata_q          <= 32'h0000_0000;
      cnt_q            <= '0;
      sel_q            <= 1'b0;
      o_cmd_timeout    <= 1'b0;
      o_mib_slave_ack  <= 1'b0;
      o_mib_ack_high_z <= 1'b1;
      o_mib_ad_high_z  <= 1'b1;
      o_mib_ad         <= 16'h0000;
    end else begin
      state_q          <= state_d;
      start_r          <= i_mib_start;
      rd_wr_n_r        <= i_mib_rd_wr_n;
      ad_r             <= i_mib_ad;
      rd_q             <= rd_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      rdata_q          <= rdata_d;
      cnt_q            <= cnt_d;
      sel_q            <= sel_d;
      o_cmd_timeout    <= timeout_d;
      o_mib_slave_ack  <= ack_d;
      o_mib_ack_high_z <= ack_hz_d;
      o_mib_ad_high_z  <= ad_hz_d;
      o_mib_ad         <= ad_d;
    end
  end

  assign cmd_master.sel       = sel_q;
  assign cmd_master.rd_wr_n   = rd_q;
  assign cmd_master.byte_addr = addr_q;
  assign cmd_master.wdata     = wdata_q;

endmodule
